// File: rtl/cosim_chk_pkg.sv
// rtl/cosim_chk_pkg.sv - shared constants and types for the cosim output checker
package cosim_chk_pkg;

   parameter int unsigned EXP_VAL = 32'd13;

   localparam int unsigned CHK_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } chk_state_e;

endpackage

// File: rtl/cosim_chk_stage.sv
// rtl/cosim_chk_stage.sv - stage-2 compare, mismatch counter and first-bad capture
module cosim_chk_stage
   import cosim_chk_pkg::*;
#(
   parameter int unsigned      WIDTH    = 128,
   parameter int unsigned      NSAMPLES = 16,
   parameter logic [WIDTH-1:0] EXPECTED = WIDTH'(EXP_VAL)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 s1_vld,
   input  logic [WIDTH-1:0]     s1_data,
   input  logic [CHK_CNT_W-1:0] s1_idx,
   output logic [CHK_CNT_W-1:0] mismatch_count,
   output logic [CHK_CNT_W-1:0] first_bad_idx,
   output logic [WIDTH-1:0]     first_bad_data,
   output logic                 last_retired
);

   localparam logic [CHK_CNT_W-1:0] LAST_IDX = CHK_CNT_W'(NSAMPLES - 1);

   logic [CHK_CNT_W-1:0] mis_cnt_q, mis_cnt_d;
   logic [CHK_CNT_W-1:0] bad_idx_q, bad_idx_d;
   logic [WIDTH-1:0]     bad_data_q, bad_data_d;
   logic                 last_ret_q, last_ret_d;

   always_comb begin
      mis_cnt_d  = mis_cnt_q;
      bad_idx_d  = bad_idx_q;
      bad_data_d = bad_data_q;
      last_ret_d = 1'b0;
      if (clear) begin
         mis_cnt_d  = '0;
         bad_idx_d  = '0;
         bad_data_d = '0;
      end else if (s1_vld) begin
         last_ret_d = (s1_idx == LAST_IDX);
         if (s1_data != EXPECTED) begin
            mis_cnt_d = mis_cnt_q + CHK_CNT_W'(1);
            // An empty counter means no earlier mismatch in this window.
            if (mis_cnt_q == '0) begin
               bad_idx_d  = s1_idx;
               bad_data_d = s1_data;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mis_cnt_q  <= '0;
         bad_idx_q  <= '0;
         bad_data_q <= '0;
         last_ret_q <= 1'b0;
      end else begin
         mis_cnt_q  <= mis_cnt_d;
         bad_idx_q  <= bad_idx_d;
         bad_data_q <= bad_data_d;
         last_ret_q <= last_ret_d;
      end
   end

   assign mismatch_count = mis_cnt_q;
   assign first_bad_idx  = bad_idx_q;
   assign first_bad_data = bad_data_q;
   assign last_retired   = last_ret_q;

endmodule

// File: rtl/cosim_out_checker.sv
// rtl/cosim_out_checker.sv - windowed capture-and-compare of the cosim spec module output
module cosim_out_checker
   import cosim_chk_pkg::*;
#(
   parameter int unsigned      WIDTH    = 128,
   parameter int unsigned      NSAMPLES = 16,
   parameter logic [WIDTH-1:0] EXPECTED = WIDTH'(EXP_VAL)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     in_data,
   output logic                 in_ready,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [CHK_CNT_W-1:0] mismatch_count,
   output logic [CHK_CNT_W-1:0] first_bad_idx,
   output logic [WIDTH-1:0]     first_bad_data
);

   localparam logic [CHK_CNT_W-1:0] LAST_IDX = CHK_CNT_W'(NSAMPLES - 1);

   chk_state_e           state_q, state_d;
   logic [CHK_CNT_W-1:0] acc_cnt_q, acc_cnt_d;
   logic                 s1_vld_q, s1_vld_d;
   logic [WIDTH-1:0]     s1_data_q, s1_data_d;
   logic [CHK_CNT_W-1:0] s1_idx_q, s1_idx_d;
   logic                 clear;
   logic                 last_retired;

   always_comb begin
      state_d   = state_q;
      acc_cnt_d = acc_cnt_q;
      s1_vld_d  = 1'b0;
      s1_data_d = s1_data_q;
      s1_idx_d  = s1_idx_q;
      clear     = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d   = RUN;
               acc_cnt_d = '0;
               s1_idx_d  = '0;
               s1_data_d = '0;
               clear     = 1'b1;
            end
         end
         RUN: begin
            if (in_valid) begin
               s1_vld_d  = 1'b1;
               s1_data_d = in_data;
               s1_idx_d  = acc_cnt_q;
               acc_cnt_d = acc_cnt_q + CHK_CNT_W'(1);
               if (acc_cnt_q == LAST_IDX) state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Wait one cycle past the final compare so results are settled when done rises.
            if (last_retired) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         acc_cnt_q <= '0;
         s1_vld_q  <= 1'b0;
         s1_data_q <= '0;
         s1_idx_q  <= '0;
      end else begin
         state_q   <= state_d;
         acc_cnt_q <= acc_cnt_d;
         s1_vld_q  <= s1_vld_d;
         s1_data_q <= s1_data_d;
         s1_idx_q  <= s1_idx_d;
      end
   end

   cosim_chk_stage #(
      .WIDTH    (WIDTH),
      .NSAMPLES (NSAMPLES),
      .EXPECTED (EXPECTED)
   ) u_stage (
      .clk            (clk),
      .rst            (rst),
      .clear          (clear),
      .s1_vld         (s1_vld_q),
      .s1_data        (s1_data_q),
      .s1_idx         (s1_idx_q),
      .mismatch_count (mismatch_count),
      .first_bad_idx  (first_bad_idx),
      .first_bad_data (first_bad_data),
      .last_retired   (last_retired)
   );

   assign in_ready = (state_q == RUN);
   assign busy     = (state_q == RUN) || (state_q == DRAIN);
   assign done     = (state_q == DONE);
   assign pass     = done && (mismatch_count == '0);

endmodule

// File: tb/tb_cosim_out_checker.sv
// tb/tb_cosim_out_checker.sv - scoreboard bench for cosim_out_checker
module tb_cosim_out_checker;

   localparam int W = 128;
   localparam int N = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_ready;
   logic         busy;
   logic         done;
   logic         pass;
   logic [7:0]   mismatch_count;
   logic [7:0]   first_bad_idx;
   logic [W-1:0] first_bad_data;

   typedef struct {
      logic [7:0]   cnt;
      logic [7:0]   idx;
      logic [W-1:0] data;
   } res_t;

   res_t         sb_q[$];
   res_t         last_exp;
   logic [W-1:0] beats [N];
   int           checks = 0;
   int           errors = 0;

   cosim_out_checker dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .in_ready       (in_ready),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .mismatch_count (mismatch_count),
      .first_bad_idx  (first_bad_idx),
      .first_bad_data (first_bad_data)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      chk_eq({tag, "_in_ready"}, W'(in_ready), W'(0));
      chk_eq({tag, "_busy"}, W'(busy), W'(0));
      chk_eq({tag, "_done"}, W'(done), W'(0));
      chk_eq({tag, "_pass"}, W'(pass), W'(0));
      chk_eq({tag, "_mis_cnt"}, W'(mismatch_count), W'(0));
      chk_eq({tag, "_bad_idx"}, W'(first_bad_idx), W'(0));
      chk_eq({tag, "_bad_data"}, first_bad_data, W'(0));
   endtask

   task automatic set_all_good();
      for (int i = 0; i < N; i++) beats[i] = W'(13);
   endtask

   task automatic drive_window(input string tag, input bit do_start, input bit toggle,
                               input bit poke_start);
      res_t e;
      int   idx;
      int   cyc;
      int   lat;
      e.cnt  = 8'd0;
      e.idx  = 8'd0;
      e.data = '0;
      for (int i = 0; i < N; i++) begin
         if (beats[i] != W'(13)) begin
            if (e.cnt == 8'd0) begin
               e.idx  = 8'(i);
               e.data = beats[i];
            end
            e.cnt++;
         end
      end
      sb_q.push_back(e);
      if (do_start) begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      chk_eq({tag, "_ready_up"}, W'(in_ready), W'(1));
      idx = 0;
      cyc = 0;
      while (idx < N && cyc < 4 * N) begin
         in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
         in_data  = beats[idx];
         start    = poke_start && (cyc == 3);
         @(posedge clk); #1;
         cyc++;
         if (in_valid) idx++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      chk_eq({tag, "_accepted"}, W'(idx), W'(N));
      chk_eq({tag, "_ready_drop"}, W'(in_ready), W'(0));
      chk_eq({tag, "_busy_drain"}, W'(busy), W'(1));
      lat = 0;
      while (!done && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      chk_eq({tag, "_done_lat"}, W'(lat), W'(2));
      if (!toggle && do_start && !poke_start)
         chk_eq({tag, "_win_cycles"}, W'(cyc + lat), W'(N + 2));
      if (sb_q.size() == 0) begin
         chk_eq({tag, "_sb_empty"}, W'(0), W'(1));
      end else begin
         e = sb_q.pop_front();
         chk_eq({tag, "_mis_cnt"}, W'(mismatch_count), W'(e.cnt));
         chk_eq({tag, "_bad_idx"}, W'(first_bad_idx), W'(e.idx));
         chk_eq({tag, "_bad_data"}, first_bad_data, e.data);
         chk_eq({tag, "_pass"}, W'(pass), W'(e.cnt == 8'd0));
         chk_eq({tag, "_busy_done"}, W'(busy), W'(0));
         last_exp = e;
      end
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      #1;
      check_reset("por");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      in_valid = 1'b1;
      in_data  = W'(14);
      repeat (3) @(posedge clk);
      #1;
      chk_eq("idle_ready", W'(in_ready), W'(0));
      chk_eq("idle_mis_cnt", W'(mismatch_count), W'(0));
      in_valid = 1'b0;

      set_all_good();
      drive_window("clean", 1'b1, 1'b0, 1'b0);

      set_all_good();
      beats[5] = W'(14);
      beats[9] = W'(14);
      drive_window("two_bad", 1'b1, 1'b0, 1'b0);

      set_all_good();
      drive_window("toggle", 1'b1, 1'b1, 1'b0);

      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1;
         in_data  = (i == 2) ? W'(14) : W'(13);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_eq("pre_abort_mis", W'(mismatch_count), W'(1));
      #2 rst = 1'b1;
      #1;
      check_reset("abort");
      @(posedge clk); #1;
      rst = 1'b0;
      set_all_good();
      drive_window("post_abort", 1'b1, 1'b0, 1'b0);

      set_all_good();
      beats[0]  = W'(7);
      beats[12] = W'(0);
      drive_window("poke", 1'b1, 1'b0, 1'b1);

      in_valid = 1'b1;
      in_data  = W'(99);
      repeat (5) @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk_eq("hold_done", W'(done), W'(1));
      chk_eq("hold_ready", W'(in_ready), W'(0));
      chk_eq("hold_mis_cnt", W'(mismatch_count), W'(last_exp.cnt));
      chk_eq("hold_bad_idx", W'(first_bad_idx), W'(last_exp.idx));
      chk_eq("hold_bad_data", first_bad_data, last_exp.data);

      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk_eq("restart_done", W'(done), W'(0));
      chk_eq("restart_ready", W'(in_ready), W'(1));
      chk_eq("restart_mis_cnt", W'(mismatch_count), W'(0));
      chk_eq("restart_bad_idx", W'(first_bad_idx), W'(0));
      chk_eq("restart_bad_data", first_bad_data, W'(0));

      set_all_good();
      beats[3] = {1'b1, 127'd13};
      drive_window("bit127", 1'b0, 1'b0, 1'b0);

      chk_eq("sb_drained", W'(sb_q.size()), W'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
